// File: rtl/lcd_hd44780_rx_if.sv
// rtl/lcd_hd44780_rx_if.sv - character-LCD pin bus between a driver and the responder
`timescale 1ns/1ps
interface lcd_hd44780_rx_if;
  logic       lcd_on;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_din;

  modport master (
    output lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_din
  );

  modport slave (
    input lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_din
  );
endinterface

// File: rtl/lcd_hd44780_rx.sv
// rtl/lcd_hd44780_rx.sv - HD44780-style bus responder with a 2x16 char buffer
`timescale 1ns/1ps
module lcd_hd44780_rx #(
  parameter int BUSY_CYC  = 40,
  parameter int CLEAR_CYC = 64
) (
  input  logic            clk,
  input  logic            rstn,
  lcd_hd44780_rx_if.slave bus,
  input  logic [4:0]      rd_addr,
  output logic [7:0]      rd_data,
  output logic            char_valid,
  output logic [7:0]      char_code,
  output logic [4:0]      char_pos,
  output logic            cmd_valid,
  output logic [7:0]      cmd_code,
  output logic            busy,
  output logic            disp_on,
  output logic [4:0]      cursor_pos,
  output logic            err_busy,
  output logic            err_addr
);
  localparam int            CW         = 16;
  localparam logic [CW-1:0] EXEC_LAST  = CW'(BUSY_CYC - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_CYC - 1);
  localparam logic [CW-1:0] INIT_LAST  = CW'(31);
  localparam logic [CW-1:0] FILL_LEN   = CW'(32);
  localparam logic [7:0]    SPACE      = 8'h20;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CLEAR} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          init_q, init_d;
  logic          fill_only_q, fill_only_d;

  logic          en_s_q, en_s_d;
  logic          rs_s_q, rs_s_d;
  logic          rw_s_q, rw_s_d;
  logic [7:0]    din_s_q, din_s_d;

  logic          ev_q, ev_d;
  logic          ev_rs_q, ev_rs_d;
  logic [7:0]    ev_din_q, ev_din_d;

  logic          char_valid_q, char_valid_d;
  logic [7:0]    char_code_q, char_code_d;
  logic [4:0]    char_pos_q, char_pos_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [7:0]    cmd_code_q, cmd_code_d;
  logic          disp_on_q, disp_on_d;
  logic [4:0]    cursor_q, cursor_d;
  logic          id_q, id_d;
  logic          err_busy_q, err_busy_d;
  logic          err_addr_q, err_addr_d;

  logic [7:0]    buf_q [32];
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [7:0]    wr_data;
  logic [CW-1:0] clear_last;

  assign busy       = (state_q != ST_IDLE);
  assign rd_data    = buf_q[rd_addr];
  assign char_valid = char_valid_q;
  assign char_code  = char_code_q;
  assign char_pos   = char_pos_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign disp_on    = disp_on_q;
  assign cursor_pos = cursor_q;
  assign err_busy   = err_busy_q;
  assign err_addr   = err_addr_q;

  always_comb begin
    en_s_d   = bus.lcd_en;
    rs_s_d   = bus.lcd_rs;
    rw_s_d   = bus.lcd_rw;
    din_s_d  = bus.lcd_din;
    // E falling edge with write direction; processed one cycle later
    ev_d     = en_s_q & ~bus.lcd_en & bus.lcd_on & ~rw_s_q;
    ev_rs_d  = rs_s_q;
    ev_din_d = din_s_q;

    state_d      = state_q;
    cnt_d        = cnt_q;
    init_d       = init_q;
    fill_only_d  = fill_only_q;
    char_valid_d = 1'b0;
    char_code_d  = char_code_q;
    char_pos_d   = char_pos_q;
    cmd_valid_d  = 1'b0;
    cmd_code_d   = cmd_code_q;
    disp_on_d    = disp_on_q;
    cursor_d     = cursor_q;
    id_d         = id_q;
    err_busy_d   = err_busy_q;
    err_addr_d   = err_addr_q;
    wr_en        = 1'b0;
    wr_addr      = cursor_q;
    wr_data      = ev_din_q;
    clear_last   = fill_only_q ? INIT_LAST : CLEAR_LAST;

    case (state_q)
      ST_IDLE: begin
        if (init_q) begin
          state_d     = ST_CLEAR;
          cnt_d       = '0;
          fill_only_d = 1'b1;
          init_d      = 1'b0;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_CLEAR: begin
        if (cnt_q < FILL_LEN) begin
          wr_en   = 1'b1;
          wr_addr = cnt_q[4:0];
          wr_data = SPACE;
        end
        if (cnt_q == clear_last) begin
          state_d     = ST_IDLE;
          fill_only_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ev_q) begin
      if (busy) err_busy_d = 1'b1;
      // a write landing during the clear fill is discarded entirely
      if (state_q != ST_CLEAR) begin
        state_d = ST_EXEC;
        cnt_d   = EXEC_LAST;
        if (ev_rs_q) begin
          wr_en        = 1'b1;
          wr_addr      = cursor_q;
          wr_data      = ev_din_q;
          char_valid_d = 1'b1;
          char_code_d  = ev_din_q;
          char_pos_d   = cursor_q;
          cursor_d     = id_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
        end else begin
          cmd_valid_d = 1'b1;
          cmd_code_d  = ev_din_q;
          casez (ev_din_q)
            8'b1???????: begin
              if (ev_din_q[6:4] == 3'b000)      cursor_d = {1'b0, ev_din_q[3:0]};
              else if (ev_din_q[6:4] == 3'b100) cursor_d = {1'b1, ev_din_q[3:0]};
              else                              err_addr_d = 1'b1;
            end
            8'b00001???: disp_on_d = ev_din_q[2];
            8'b000001??: id_d      = ev_din_q[1];
            8'b0000001?: cursor_d  = 5'd0;
            8'b00000001: begin
              cursor_d    = 5'd0;
              id_d        = 1'b1;
              state_d     = ST_CLEAR;
              cnt_d       = '0;
              fill_only_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      init_q       <= 1'b1;
      fill_only_q  <= 1'b0;
      en_s_q       <= 1'b0;
      rs_s_q       <= 1'b0;
      rw_s_q       <= 1'b0;
      din_s_q      <= 8'h00;
      ev_q         <= 1'b0;
      ev_rs_q      <= 1'b0;
      ev_din_q     <= 8'h00;
      char_valid_q <= 1'b0;
      char_code_q  <= 8'h00;
      char_pos_q   <= 5'd0;
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= 8'h00;
      disp_on_q    <= 1'b0;
      cursor_q     <= 5'd0;
      id_q         <= 1'b1;
      err_busy_q   <= 1'b0;
      err_addr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      init_q       <= init_d;
      fill_only_q  <= fill_only_d;
      en_s_q       <= en_s_d;
      rs_s_q       <= rs_s_d;
      rw_s_q       <= rw_s_d;
      din_s_q      <= din_s_d;
      ev_q         <= ev_d;
      ev_rs_q      <= ev_rs_d;
      ev_din_q     <= ev_din_d;
      char_valid_q <= char_valid_d;
      char_code_q  <= char_code_d;
      char_pos_q   <= char_pos_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_code_q   <= cmd_code_d;
      disp_on_q    <= disp_on_d;
      cursor_q     <= cursor_d;
      id_q         <= id_d;
      err_busy_q   <= err_busy_d;
      err_addr_q   <= err_addr_d;
    end
  end

  // buffer is plain storage; contents only change through the write port
  always_ff @(posedge clk) begin
    if (wr_en && !rstn) buf_q[wr_addr] <= wr_data;
  end
endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// tb/tb_lcd_hd44780_rx.sv - randomized bench for lcd_hd44780_rx with a timestamp-based model
`timescale 1ns/1ps
module tb_lcd_hd44780_rx;
  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic       char_valid, cmd_valid, busy, disp_on, err_busy, err_addr;
  logic [7:0] char_code, cmd_code;
  logic [4:0] char_pos, cursor_pos;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  lcd_hd44780_rx_if bus();

  lcd_hd44780_rx #(.BUSY_CYC(40), .CLEAR_CYC(64)) dut (
    .clk(clk), .rstn(rstn), .bus(bus.slave), .rd_addr(rd_addr), .rd_data(rd_data),
    .char_valid(char_valid), .char_code(char_code), .char_pos(char_pos),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .busy(busy), .disp_on(disp_on),
    .cursor_pos(cursor_pos), .err_busy(err_busy), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic       rs;
    logic [7:0] d;
  } ev_t;
  ev_t evq[$];

  logic [7:0] mbuf [32];
  bit         known [32];
  int         mcur = 0;
  bit         mid = 1'b1, mdisp = 1'b0, meb = 1'b0, mea = 1'b0;
  int         busy_end = 0, clear_start = -1000;
  bit         in_clear = 1'b0, init_pend = 1'b0;
  bit         e_cv = 1'b0, e_mv = 1'b0;
  logic [7:0] e_cc = 8'h00, e_mc = 8'h00;
  int         e_cp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: effects are applied at the edge where the spec says they become visible
  always @(posedge clk) begin
    bit   busy_prev;
    ev_t  e;
    int   hb;
    cyc++;
    e_cv = 1'b0;
    e_mv = 1'b0;
    if (rstn) begin
      mcur = 0; mid = 1'b1; mdisp = 1'b0; meb = 1'b0; mea = 1'b0;
      busy_end = 0; in_clear = 1'b0; init_pend = 1'b1; clear_start = -1000;
      e_cc = 8'h00; e_mc = 8'h00; e_cp = 0;
      evq.delete();
    end else begin
      busy_prev = (cyc - 1) < busy_end;
      if (init_pend) begin
        init_pend = 1'b0; clear_start = cyc; busy_end = cyc + 32; in_clear = 1'b1;
      end
      if (in_clear && (cyc - clear_start) >= 1 && (cyc - clear_start) <= 32) begin
        mbuf[cyc - clear_start - 1]  = 8'h20;
        known[cyc - clear_start - 1] = 1'b1;
      end
      while (evq.size() > 0 && evq[0].at == cyc) begin
        e = evq.pop_front();
        if (busy_prev) meb = 1'b1;
        if (!(busy_prev && in_clear)) begin
          busy_end = cyc + 40;
          in_clear = 1'b0;
          if (e.rs) begin
            mbuf[mcur] = e.d; known[mcur] = 1'b1;
            e_cv = 1'b1; e_cc = e.d; e_cp = mcur;
            mcur = mid ? (mcur + 1) % 32 : (mcur + 31) % 32;
          end else begin
            e_mv = 1'b1; e_mc = e.d;
            hb = -1;
            for (int b = 7; b >= 0; b--) if (e.d[b]) begin hb = b; break; end
            case (hb)
              7: begin
                if (e.d < 8'h90)                        mcur = e.d - 8'h80;
                else if (e.d >= 8'hC0 && e.d <= 8'hCF) mcur = 16 + (e.d - 8'hC0);
                else                                    mea = 1'b1;
              end
              3: mdisp = e.d[2];
              2: mid = e.d[1];
              1: mcur = 0;
              0: begin
                mcur = 0; mid = 1'b1; in_clear = 1'b1;
                clear_start = cyc; busy_end = cyc + 64;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("char_valid", char_valid, e_cv);
      if (e_cv) begin
        chk("char_code", char_code, e_cc);
        chk("char_pos", char_pos, e_cp);
      end
      chk("cmd_valid", cmd_valid, e_mv);
      if (e_mv) chk("cmd_code", cmd_code, e_mc);
      chk("busy", busy, cyc < busy_end);
      chk("cursor_pos", cursor_pos, mcur);
      chk("disp_on", disp_on, mdisp);
      chk("err_busy", err_busy, meb);
      chk("err_addr", err_addr, mea);
      if (known[rd_addr]) chk("rd_data", rd_data, mbuf[rd_addr]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rnd_rd);
    for (int i = 0; i < n; i++) begin
      if (rnd_rd) rd_addr = 5'($urandom);
      step();
    end
  endtask

  task automatic strobe(input logic rs, input logic [7:0] d, input logic rw, input logic on,
                        input int hold);
    ev_t e;
    bus.lcd_rs = rs; bus.lcd_din = d; bus.lcd_rw = rw; bus.lcd_on = on; bus.lcd_en = 1'b1;
    repeat (hold) step();
    bus.lcd_en = 1'b0;
    if (on && !rw) begin
      e.at = cyc + 2; e.rs = rs; e.d = d;
      evq.push_back(e);
    end
    step();
    step();
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    step();
    step();
    rstn = 1'b0;
  endtask

  task automatic chk_rd(input string nm, input logic [4:0] a, input logic [7:0] exp);
    rd_addr = a;
    step();
    chk(nm, rd_data, exp);
  endtask

  initial begin
    logic       rs, rw, on;
    logic [7:0] d;
    bus.lcd_on = 1'b1; bus.lcd_en = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_din = 8'h00;
    for (int i = 0; i < 32; i++) known[i] = 1'b0;

    // reset and power-on fill
    step();
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_cursor", cursor_pos, 5'd0);
    rstn = 1'b0;
    idle(32, 1'b0);
    chk("init_busy_hi", busy, 1'b1);
    step();
    chk("init_busy_lo", busy, 1'b0);
    for (int i = 0; i < 32; i++) chk_rd("init_space", 5'(i), 8'h20);

    // clear then first character
    strobe(1'b0, 8'h01, 1'b0, 1'b1, 2);
    idle(66, 1'b0);
    strobe(1'b1, 8'h35, 1'b0, 1'b1, 2);
    chk("t2_char_valid", char_valid, 1'b1);
    chk("t2_char_code", char_code, 8'h35);
    chk("t2_char_pos", char_pos, 5'd0);
    chk("t2_cursor", cursor_pos, 5'd1);
    idle(45, 1'b0);
    chk_rd("t2_rd0", 5'd0, 8'h35);

    // line addressing and 15->16 wrap
    strobe(1'b0, 8'hC0, 1'b0, 1'b1, 1); idle(45, 1'b0);
    strobe(1'b1, 8'h41, 1'b0, 1'b1, 1);
    chk("t3_pos16", char_pos, 5'd16);
    idle(45, 1'b0);
    strobe(1'b0, 8'h8F, 1'b0, 1'b1, 1); idle(45, 1'b0);
    strobe(1'b1, 8'h41, 1'b0, 1'b1, 1);
    chk("t3_pos15", char_pos, 5'd15);
    idle(45, 1'b0);
    strobe(1'b1, 8'h42, 1'b0, 1'b1, 1);
    chk("t3_pos16b", char_pos, 5'd16);
    idle(45, 1'b0);
    chk_rd("t3_rd15", 5'd15, 8'h41);
    chk_rd("t3_rd16", 5'd16, 8'h42);

    // decrement mode wraps 0 -> 31
    strobe(1'b0, 8'h01, 1'b0, 1'b1, 1); idle(66, 1'b0);
    strobe(1'b0, 8'h04, 1'b0, 1'b1, 1); idle(45, 1'b0);
    strobe(1'b1, 8'h31, 1'b0, 1'b1, 1);
    chk("t4_pos", char_pos, 5'd0);
    chk("t4_cursor", cursor_pos, 5'd31);

    // write 10 cycles after the previous one, then a write during clear
    idle(4, 1'b0);
    strobe(1'b1, 8'h32, 1'b0, 1'b1, 4);
    chk("t5_err_busy", err_busy, 1'b1);
    chk("t5_written", char_valid, 1'b1);
    idle(45, 1'b0);
    strobe(1'b0, 8'h01, 1'b0, 1'b1, 1);
    idle(3, 1'b0);
    strobe(1'b1, 8'h77, 1'b0, 1'b1, 1);
    chk("t5_dropped", char_valid, 1'b0);
    idle(70, 1'b0);
    chk_rd("t5_rd0", 5'd0, 8'h20);

    // ignored strobes and unmapped DDRAM address
    do_reset();
    idle(40, 1'b0);
    strobe(1'b1, 8'h55, 1'b1, 1'b1, 1);
    chk("t6_rw_pulse", char_valid, 1'b0);
    strobe(1'b1, 8'h56, 1'b0, 1'b0, 1);
    chk("t6_off_pulse", char_valid, 1'b0);
    chk("t6_no_err", err_busy, 1'b0);
    strobe(1'b0, 8'h90, 1'b0, 1'b1, 1);
    chk("t6_cmd_valid", cmd_valid, 1'b1);
    chk("t6_err_addr", err_addr, 1'b1);
    chk("t6_cursor", cursor_pos, 5'd0);
    idle(45, 1'b0);

    // reset in the middle of a clear
    strobe(1'b0, 8'h01, 1'b0, 1'b1, 1);
    idle(5, 1'b0);
    do_reset();
    idle(40, 1'b1);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      rs = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      if (!rs && d == 8'h01 && $urandom_range(0, 3) != 0) d = 8'h06;
      rw = ($urandom_range(0, 9) == 0);
      on = ($urandom_range(0, 9) != 0);
      strobe(rs, d, rw, on, $urandom_range(1, 3));
      idle($urandom_range(0, 60), 1'b1);
    end
    idle(70, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
